// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nn_pkg
// Purpose  : Shared FSM state encoding and activation-mode constants for the
//            sequential perceptron.
// Revision : 1.0 - initial release
// ============================================================================
package nn_pkg;

   // Controller states: accept, multiply-accumulate, activate, present result
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_ACT   = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

   // act_mode encodings; code 3 falls back to identity
   localparam logic [1:0] ACT_IDENT = 2'd0;
   localparam logic [1:0] ACT_RELU  = 2'd1;
   localparam logic [1:0] ACT_STEP  = 2'd2;

endpackage : nn_pkg
`default_nettype wire

// File: rtl/perceptron_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : perceptron_seq_if
// Purpose  : Input-vector, result and coefficient-write bus of the perceptron.
//            master = producer/consumer side, slave = perceptron side.
// Revision : 1.0 - initial release
// ============================================================================
interface perceptron_seq_if #(
   parameter int N_INPUTS = 4,
   parameter int DATA_W   = 16
) ();

   logic                                in_valid;
   logic                                in_ready;
   logic [N_INPUTS*DATA_W-1:0]          in_data;
   logic [1:0]                          act_mode;
   logic                                w_wr_en;
   logic [$clog2(N_INPUTS+1)-1:0]       w_wr_addr;
   logic [DATA_W-1:0]                   w_wr_data;
   logic                                w_wr_err;
   logic                                out_valid;
   logic                                out_ready;
   logic [DATA_W-1:0]                   out_data;

   modport master (
      output in_valid, in_data, act_mode, w_wr_en, w_wr_addr, w_wr_data, out_ready,
      input  in_ready, w_wr_err, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, act_mode, w_wr_en, w_wr_addr, w_wr_data, out_ready,
      output in_ready, w_wr_err, out_valid, out_data
   );

endinterface : perceptron_seq_if
`default_nettype wire

// File: rtl/nn_activation.sv
`default_nettype none
// ============================================================================
// Module   : nn_activation
// Purpose  : Combinational rescale (floor shift), saturation to DATA_W and
//            activation function of the accumulated dot product.
// Revision : 1.0 - initial release
// ============================================================================
module nn_activation
   import nn_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 12,
   parameter int ACC_W  = 34
) (
   input  wire logic signed [ACC_W-1:0]  acc_i,
   input  wire logic        [1:0]        mode_i,
   output logic             [DATA_W-1:0] data_o
);

   localparam logic signed [ACC_W-1:0] c_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] c_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   logic signed [ACC_W-1:0]  w_shr;
   logic        [DATA_W-1:0] w_sat;

   // Arithmetic shift floors toward -inf; then clamp into the signed DATA_W range
   always_comb begin
      w_shr = acc_i >>> FRAC_W;
      w_sat = w_shr[DATA_W-1:0];
      if (w_shr > c_MAX) begin
         w_sat = {1'b0, {(DATA_W-1){1'b1}}};
      end else if (w_shr < c_MIN) begin
         w_sat = {1'b1, {(DATA_W-1){1'b0}}};
      end
   end

   // Step yields an integer 1 (not 1.0 in Q format) for strictly positive sums
   always_comb begin
      data_o = w_sat;
      case (mode_i)
         ACT_RELU: data_o = w_sat[DATA_W-1] ? '0 : w_sat;
         ACT_STEP: data_o = (!w_sat[DATA_W-1] && (w_sat != '0)) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
         default:  data_o = w_sat;
      endcase
   end

endmodule : nn_activation
`default_nettype wire

// File: rtl/perceptron_seq.sv
`default_nettype none
// ============================================================================
// Module   : perceptron_seq
// Purpose  : Single-multiplier sequential perceptron. Accepts an N_INPUTS
//            vector, accumulates weight*input plus bias over N_INPUTS cycles,
//            applies a selectable activation and holds the result until taken.
// Revision : 1.0 - initial release
// ============================================================================
module perceptron_seq
   import nn_pkg::*;
#(
   parameter int N_INPUTS = 4,
   parameter int DATA_W   = 16,
   parameter int FRAC_W   = 12
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   perceptron_seq_if.slave    bus
);

   localparam int c_AW    = $clog2(N_INPUTS+1);
   localparam int c_ACC_W = 2*DATA_W + c_AW;
   localparam logic [c_AW-1:0] c_BIAS_ADDR = c_AW'(N_INPUTS);
   localparam logic [c_AW-1:0] c_LAST_CH   = c_AW'(N_INPUTS-1);

   state_t                      state_q;
   logic signed [DATA_W-1:0]    coef_q [N_INPUTS+1];
   logic [N_INPUTS*DATA_W-1:0]  data_q;
   logic [1:0]                  mode_q;
   logic [c_AW-1:0]             cnt_q;
   logic signed [c_ACC_W-1:0]   acc_q;
   logic signed [c_ACC_W-1:0]   acc_d;
   logic                        in_ready_q;
   logic                        out_valid_q;
   logic [DATA_W-1:0]           out_data_q;
   logic                        wr_err_q;

   logic                        w_accept;
   logic                        w_wr_ok;
   logic signed [DATA_W-1:0]    w_bias_cur;
   logic signed [c_ACC_W-1:0]   w_bias_ext;
   logic signed [2*DATA_W-1:0]  w_prod;
   logic [DATA_W-1:0]           w_act;

   assign w_accept = bus.in_valid && in_ready_q;
   assign w_wr_ok  = bus.w_wr_en && (state_q == ST_IDLE) && (bus.w_wr_addr <= c_BIAS_ADDR);

   // A bias written in the accept cycle must seed this vector's accumulator
   assign w_bias_cur = (w_wr_ok && (bus.w_wr_addr == c_BIAS_ADDR)) ? $signed(bus.w_wr_data)
                                                                   : coef_q[c_BIAS_ADDR];
   assign w_bias_ext = {{(c_ACC_W-DATA_W){w_bias_cur[DATA_W-1]}}, w_bias_cur};

   // Channel 0 sits in the low slice of data_q; the register shifts down each MAC
   assign w_prod = $signed(data_q[DATA_W-1:0]) * coef_q[cnt_q];
   assign acc_d  = acc_q + {{(c_ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};

   nn_activation #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (c_ACC_W)
   ) u_act (
      .acc_i  (acc_q),
      .mode_i (mode_q),
      .data_o (w_act)
   );

   // Coefficient register file: writes only land while idle and in range
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i <= N_INPUTS; i++) begin
            coef_q[i] <= '0;
         end
      end else if (w_wr_ok) begin
         coef_q[bus.w_wr_addr] <= bus.w_wr_data;
      end
   end

   // Dropped-write indicator: one-cycle pulse for any strobe that was not applied
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_err_q <= 1'b0;
      end else begin
         wr_err_q <= bus.w_wr_en && !w_wr_ok;
      end
   end

   // Main controller with registered handshake outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         acc_q       <= '0;
         data_q      <= '0;
         mode_q      <= ACT_IDENT;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               in_ready_q <= 1'b1;
               if (w_accept) begin
                  in_ready_q <= 1'b0;
                  data_q     <= bus.in_data;
                  mode_q     <= bus.act_mode;
                  acc_q      <= w_bias_ext <<< FRAC_W;
                  cnt_q      <= '0;
                  state_q    <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               acc_q  <= acc_d;
               data_q <= data_q >> DATA_W;
               cnt_q  <= cnt_q + c_AW'(1);
               if (cnt_q == c_LAST_CH) begin
                  state_q <= ST_ACT;
               end
            end
            ST_ACT: begin
               out_data_q  <= w_act;
               out_valid_q <= 1'b1;
               state_q     <= ST_OUT;
            end
            ST_OUT: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.w_wr_err  = wr_err_q;

endmodule : perceptron_seq
`default_nettype wire
